fifo_ctrl_2to1: RTL and testbench

FIFO_CTRL_2TO1 -- requirements
Module: fifo_ctrl_2to1

---
 rtl/fifo_ctrl_2to1_if.sv | 25 ++
 rtl/fifo_ctrl_2to1.sv | 94 +++++++++
 tb/tb_fifo_ctrl_2to1.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_2to1_if.sv
// Handshake and status bundle between a 2:1 width-converting FIFO controller
// and its user. The user drives rd/wr; the controller drives everything else.
interface fifo_ctrl_2to1_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  rd;
  logic                  wr;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_half;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH+1:0] count;

  modport master (
    output rd, wr,
    input  w_en, w_addr, r_addr, r_half, empty, full, count
  );

  modport slave (
    input  rd, wr,
    output w_en, w_addr, r_addr, r_half, empty, full, count
  );
endinterface

// File: rtl/fifo_ctrl_2to1.sv
// Pointer/flag controller for a FIFO that is written one full word at a time
// and read one half-word at a time; the register file itself lives outside.
//
// Read-half FSM:
//   state      | meaning
//   HALF_UPPER | next read returns the upper half of the head word
//   HALF_LOWER | next read returns the lower half and then frees the head word
module fifo_ctrl_2to1 #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  fifo_ctrl_2to1_if.slave   bus
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {
    HALF_UPPER = 1'b0,
    HALF_LOWER = 1'b1
  } half_state_t;

  half_state_t   half_q;
  half_state_t   half_d;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW+1:0] count_q;
  logic [AW+1:0] count_d;
  logic          empty_c;
  logic          full_c;
  logic          rd_ok;
  logic          wr_acc;
  logic          rd_adv;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign rd_ok   = bus.rd & ~empty_c;
  // A full buffer can still take a word when this cycle's read frees the head slot.
  assign wr_acc  = bus.wr & (~full_c | (rd_ok & (half_q == HALF_LOWER)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_q <= HALF_UPPER;
    end else begin
      half_q <= half_d;
    end
  end

  always_comb begin
    half_d = half_q;
    rd_adv = 1'b0;
    case (half_q)
      HALF_UPPER: begin
        if (rd_ok) half_d = HALF_LOWER;
      end
      HALF_LOWER: begin
        if (rd_ok) begin
          half_d = HALF_UPPER;
          rd_adv = 1'b1;
        end
      end
      default: begin
        half_d = HALF_UPPER;
      end
    endcase
  end

  assign count_d = count_q
                 + {{AW{1'b0}}, wr_acc, 1'b0}
                 - {{(AW+1){1'b0}}, rd_ok};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_d;
    end
  end

  assign bus.w_en   = wr_acc;
  assign bus.w_addr = wr_ptr[AW-1:0];
  assign bus.r_addr = rd_ptr[AW-1:0];
  assign bus.r_half = (half_q == HALF_LOWER);
  assign bus.empty  = empty_c;
  assign bus.full   = full_c;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_fifo_ctrl_2to1.sv
// Scoreboard bench for fifo_ctrl_2to1: the driver queues expected per-cycle
// responses, a monitor compares them and tracks half-word ordering.
module tb_fifo_ctrl_2to1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fifo_ctrl_2to1_if #(.ADDR_WIDTH(4)) bus ();

  fifo_ctrl_2to1 #(.ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         step;
    logic       wen;
    logic       empty;
    logic       full;
    logic [5:0] count;
    logic [3:0] raddr;
    logic       rhalf;
    logic [3:0] waddr;
  } exp_t;

  exp_t sq[$];
  int   hq[$];
  int   mem [16];
  int   next_word = 1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   step_no = 0;

  logic [4:0] m_wp = '0;
  logic [4:0] m_rp = '0;
  logic       m_half = 1'b0;

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  function automatic logic [5:0] m_count();
    logic [4:0] diff;
    diff = m_wp - m_rp;
    return {diff, 1'b0} - {5'd0, m_half};
  endfunction

  // Advances the reference model by one cycle; returns the pre-edge w_en and acceptance.
  task automatic model_step(input logic r, input logic w, output logic rdok, output logic wacc);
    logic m_empty, m_full;
    m_empty = (m_wp == m_rp);
    m_full  = (m_wp[3:0] == m_rp[3:0]) && (m_wp[4] != m_rp[4]);
    rdok = r & ~m_empty;
    wacc = w & (~m_full | (rdok & m_half));
    if (rdok) begin
      if (m_half) m_rp = m_rp + 5'd1;
      m_half = ~m_half;
    end
    if (wacc) m_wp = m_wp + 5'd1;
  endtask

  task automatic step(input logic r, input logic w, output logic rdok, output logic wacc);
    exp_t e;
    @(negedge clk);
    bus.rd = r;
    bus.wr = w;
    model_step(r, w, rdok, wacc);
    step_no++;
    e.step  = step_no;
    e.wen   = wacc;
    e.empty = (m_wp == m_rp);
    e.full  = (m_wp[3:0] == m_rp[3:0]) && (m_wp[4] != m_rp[4]);
    e.count = m_count();
    e.raddr = m_rp[3:0];
    e.rhalf = m_half;
    e.waddr = m_wp[3:0];
    sq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Directed step with hand-computed expectations.
  task automatic step_x(input logic r, input logic w, input logic wen, input logic emp,
                        input logic ful, input logic [5:0] cnt, input logic [3:0] ra,
                        input logic rh);
    exp_t e;
    logic rdok, wacc;
    @(negedge clk);
    bus.rd = r;
    bus.wr = w;
    model_step(r, w, rdok, wacc);
    step_no++;
    e.step  = step_no;
    e.wen   = wen;
    e.empty = emp;
    e.full  = ful;
    e.count = cnt;
    e.raddr = ra;
    e.rhalf = rh;
    e.waddr = m_wp[3:0];
    sq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    for (int i = 0; i < 10 && sq.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", step_no, sq.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, step_no, bus.empty, 1);
    check({tag, "_full"}, step_no, bus.full, 0);
    check({tag, "_count"}, step_no, bus.count, 0);
    check({tag, "_raddr"}, step_no, bus.r_addr, 0);
    check({tag, "_waddr"}, step_no, bus.w_addr, 0);
    check({tag, "_rhalf"}, step_no, bus.r_half, 0);
  endtask

  // Monitor: w_en and read ordering before the edge, registered state after it.
  initial begin
    exp_t e;
    int   exp_h;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() > 0 && !reset) begin
        e = sq[0];
        check("w_en", e.step, bus.w_en, e.wen);
        if (bus.rd && !bus.empty) begin
          if (hq.size() == 0) begin
            check("rd_underflow", e.step, 1, 0);
          end else begin
            exp_h = hq.pop_front();
            check("rd_order", e.step, mem[bus.r_addr] * 2 + int'(bus.r_half), exp_h);
          end
        end
        if (bus.w_en) begin
          mem[bus.w_addr] = next_word;
          hq.push_back(next_word * 2);
          hq.push_back(next_word * 2 + 1);
          next_word++;
        end
        @(posedge clk);
        #1;
        check("empty", e.step, bus.empty, e.empty);
        check("full", e.step, bus.full, e.full);
        check("count", e.step, bus.count, e.count);
        check("r_addr", e.step, bus.r_addr, e.raddr);
        check("r_half", e.step, bus.r_half, e.rhalf);
        check("w_addr", e.step, bus.w_addr, e.waddr);
        void'(sq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ra, wa;
    int   wdone, rdone;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    @(negedge clk);
    reset = 1'b0;

    // single write, then two half reads
    step_x(0, 1, 1, 0, 0, 6'd2, 4'd0, 0);
    step_x(1, 0, 0, 0, 0, 6'd1, 4'd0, 1);
    step_x(1, 0, 0, 1, 0, 6'd0, 4'd1, 0);
    // read on empty ignored; rd+wr on empty accepts only the write
    step_x(1, 0, 0, 1, 0, 6'd0, 4'd1, 0);
    step_x(1, 1, 1, 0, 0, 6'd2, 4'd1, 0);
    // fill to 16 words
    for (int i = 1; i <= 15; i++)
      step_x(0, 1, 1, 0, (i == 15), 6'(2 + 2 * i), 4'd1, 0);
    step_x(0, 1, 0, 0, 1, 6'd32, 4'd1, 0);
    // full: rd+wr at upper half rejects the write, at lower half accepts it
    step_x(1, 1, 0, 0, 1, 6'd31, 4'd1, 1);
    step_x(1, 1, 1, 0, 1, 6'd32, 4'd2, 0);
    // drain completely with the model
    for (int i = 0; i < 33; i++) step(1, 0, ra, wa);
    step(1, 1, ra, wa);
    step(1, 0, ra, wa);

    // mixed traffic, then reset with data in flight
    for (int i = 0; i < 12; i++) step((i % 3 == 0), 1'b1, ra, wa);
    drain();
    check("pre_reset_nonzero", step_no, (bus.count != 0), 1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("rst_mid");
    m_wp = '0;
    m_rp = '0;
    m_half = 1'b0;
    hq.delete();
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    // 40 words in, 80 halves out, pointers wrap past 31
    wdone = 0;
    rdone = 0;
    for (int i = 0; i < 400 && (wdone < 40 || rdone < 80); i++) begin
      step((rdone < 80) && (i % 4 != 0), (wdone < 40) && (i % 5 != 3), ra, wa);
      if (ra) rdone++;
      if (wa) wdone++;
    end
    drain();
    check("final_empty", step_no, bus.empty, 1);
    check("final_halves_left", step_no, hq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
